// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the checksum (CHK) state.
package loader_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLen, StData, StWrite, StChk, StDone
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StLen, StData, StWrite, StDone
    } state_t;
`endif

    // Length byte to word count: 0 means 256, clamped to the memory size.
    function automatic int unsigned decode_len(input logic [7:0] len, input int unsigned addr_w);
        int unsigned n;
        n = (len == 8'd0) ? 32'd256 : {24'd0, len};
        if (addr_w < 9 && n > (32'd1 << addr_w)) begin
            n = 32'd1 << addr_w;
        end
        return n;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes MSB-first into a word and flags the byte that completes it.
module byte_packer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [7:0]        data_byte,
    input  logic              clear,
    output logic [DATA_W-1:0] word,
    output logic              last_byte
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] word_q;

    // Byte counter and assembly register; clear drops any partial word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (shift_en) begin
            word_q <= (word_q << 8) | DATA_W'(data_byte);
            cnt_q  <= last_byte ? '0 : cnt_q + 1'b1;
        end
    end

    assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));
    assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding
// the CPU in reset. Optional macro: IMEM_LOADER_CHECKSUM_EN (trailing sum byte).
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8 * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic              csum_err
`endif
);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] last_idx_q;
    logic              xfer;
    logic              shift_en;
    logic              clear;
    logic              last_byte;
    logic [DATA_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer     = in_valid && in_ready;
    assign shift_en = xfer && (state_q == StData);
    assign clear    = (state_q == StLen);
    assign wr_addr  = idx_q;
    assign wr_data  = word;

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .data_byte (in_data),
        .clear     (clear),
        .word      (word),
        .last_byte (last_byte)
    );

    // Load sequencer with registered handshake, strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_idx_q <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
            csum_err   <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StLen;
                        busy     <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        in_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_err <= 1'b0;
`endif
                    end
                end
                StLen: begin
                    if (xfer) begin
                        last_idx_q <= ADDR_W'(decode_len(in_data, ADDR_W) - 32'd1);
                        idx_q      <= '0;
                        state_q    <= StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= 8'd0;
`endif
                    end
                end
                StData: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q + in_data;
`endif
                        if (last_byte) begin
                            state_q  <= StWrite;
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q  <= StChk;
                        in_ready <= 1'b1;
`else
                        state_q  <= StDone;
`endif
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        state_q  <= StData;
                        in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q <= StDone;
                        end else begin
                            // CPU stays in reset: the image is not trusted.
                            csum_err <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
`endif
                StDone: begin
                    cpu_rst <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Optional macro: IMEM_LOADER_CHECKSUM_EN adds checksum bytes and tests.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        csum_err;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_data[$];
    int          dbl_wr = 0;
    int          wr_rdy = 0;
    logic        wr_en_prev = 1'b0;
    logic [7:0]  csum_acc = 8'd0;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .csum_err (csum_err)
`endif
    );

    // Capture every write strobe; flag multi-cycle strobes and strobes overlapping in_ready.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            if (wr_en_prev === 1'b1) dbl_wr++;
            if (in_ready === 1'b1) wr_rdy++;
        end
        wr_en_prev = wr_en;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte and return at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("hs_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        csum_acc = csum_acc + b;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_load(input logic [7:0] len);
        got_addr.delete();
        got_data.delete();
        start_pulse();
        send_byte(len);
        csum_acc = 8'd0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic end_load(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
        wait_done(tag);
    endtask

    initial begin
        int bad;
        logic [7:0] b;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_en",    {63'd0, wr_en},    64'd0);
        chk("rst_wr_addr",  {56'd0, wr_addr},  64'd0);
        chk("rst_wr_data",  {32'd0, wr_data},  64'd0);
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_cpu_rst",  {63'd0, cpu_rst},  64'd1);

        // Idle bus for 100 cycles
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cpu_rst !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        chk("idle100_bad", bad, 0);

        // Two-word load, back-to-back bytes
        begin_load(8'h02);
        chk("t1_busy",    {63'd0, busy},    64'd1);
        chk("t1_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        send_word(32'h2008_0005, 0);
        chk("t1_lat_wr_en",  {63'd0, wr_en},   64'd1);
        chk("t1_lat_addr",   {56'd0, wr_addr}, 64'd0);
        chk("t1_lat_data",   {32'd0, wr_data}, 64'h2008_0005);
        chk("t1_write_rdy",  {63'd0, in_ready}, 64'd0);
        send_word(32'h0000_0008, 0);
        end_load("t1_done");
        chk("t1_cpu_rst_end", {63'd0, cpu_rst}, 64'd0);
        chk("t1_busy_end",    {63'd0, busy},    64'd0);
        chk("t1_nwr",   got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            chk("t1_a0", {56'd0, got_addr[0]}, 64'd0);
            chk("t1_d0", {32'd0, got_data[0]}, 64'h2008_0005);
            chk("t1_a1", {56'd0, got_addr[1]}, 64'd1);
            chk("t1_d1", {32'd0, got_data[1]}, 64'h0000_0008);
        end

        // Start pulsed mid-load is ignored
        begin_load(8'h03);
        chk("t3_done_clr", {63'd0, done}, 64'd0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        start_pulse();
        chk("t3_busy_mid", {63'd0, busy},     64'd1);
        chk("t3_rdy_mid",  {63'd0, in_ready}, 64'd1);
        send_byte(8'h77);
        send_byte(8'h88);
        send_word(32'h99AA_BBCC, 1);
        end_load("t3_done");
        chk("t3_nwr", got_addr.size(), 3);
        if (got_addr.size() == 3) begin
            chk("t3_a2", {56'd0, got_addr[2]}, 64'd2);
            chk("t3_d0", {32'd0, got_data[0]}, 64'h1122_3344);
            chk("t3_d1", {32'd0, got_data[1]}, 64'h5566_7788);
            chk("t3_d2", {32'd0, got_data[2]}, 64'h99AA_BBCC);
        end

        // L=0 means 256 words, with random stalls on in_valid
        exp_data.delete();
        begin_load(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            exp_data.push_back({b, ~b, b ^ 8'h5a, b + 8'd3});
            send_word({b, ~b, b ^ 8'h5a, b + 8'd3}, 2);
        end
        end_load("t2_done");
        chk("t2_nwr", got_addr.size(), 256);
        if (got_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("t2_a%0d", i), {56'd0, got_addr[i]}, i);
                chk($sformatf("t2_d%0d", i), {32'd0, got_data[i]}, {32'd0, exp_data[i]});
            end
        end
        chk("t2_dbl_wr",  dbl_wr, 0);
        chk("t2_wr_rdy",  wr_rdy, 0);

        // Reset mid-load, then a clean single-word load
        begin_load(8'h02);
        send_word(32'h0102_0304, 0);
        send_byte(8'h05);
        send_byte(8'h06);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_busy",     {63'd0, busy},     64'd0);
        chk("t4_cpu_rst",  {63'd0, cpu_rst},  64'd1);
        chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t4_done",     {63'd0, done},     64'd0);
        begin_load(8'h01);
        send_word(32'hAABB_CCDD, 0);
        end_load("t4_done_end");
        chk("t4_nwr", got_addr.size(), 1);
        if (got_addr.size() == 1) begin
            chk("t4_a0", {56'd0, got_addr[0]}, 64'd0);
            chk("t4_d0", {32'd0, got_data[0]}, 64'hAABB_CCDD);
        end
        chk("t4_cpu_rst_end", {63'd0, cpu_rst}, 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match: 01+02+03+04 = 0A
        begin_load(8'h01);
        send_word(32'h0102_0304, 0);
        send_byte(8'h0A);
        wait_done("c_ok_done");
        chk("c_ok_err", {63'd0, csum_err}, 64'd0);
        // Checksum mismatch
        begin_load(8'h01);
        send_word(32'h0102_0304, 0);
        send_byte(8'h0B);
        repeat (3) @(negedge clk);
        chk("c_bad_err",     {63'd0, csum_err}, 64'd1);
        chk("c_bad_cpu_rst", {63'd0, cpu_rst},  64'd1);
        chk("c_bad_busy",    {63'd0, busy},     64'd0);
        chk("c_bad_done",    {63'd0, done},     64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
